// File: rtl/shot_resolver_pkg.sv
// Shared encodings for the zapper firing FSM and the shot resolver.
package shot_resolver_pkg;

  typedef enum logic [1:0] {
    FIRE_RELOAD = 2'b00,
    FIRE_HOLD   = 2'b01,
    FIRE_SHOT   = 2'b11
  } fire_state_e;

  typedef enum logic [1:0] {
    RES_IDLE   = 2'b00,
    RES_BLANK  = 2'b01,
    RES_TARGET = 2'b10,
    RES_RESULT = 2'b11
  } res_state_e;

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/shot_resolver_timer.sv
// flash_timer: loadable down-counter, done while the count sits at 1.
module flash_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign done = (cnt_q == W'(1));

endmodule

// File: rtl/shot_resolver.sv
// Light-gun shot resolver: black frame, target frame, then hit/miss verdict.
module shot_resolver
  import shot_resolver_pkg::*;
#(
  parameter int BLANK_CYCLES  = 4,
  parameter int TARGET_CYCLES = 4,
  parameter int AMMO_MAX      = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] STATE,
  input  logic       light_sensor,
  input  logic       new_round,
  output logic       flash_black,
  output logic       flash_target,
  output logic       hit,
  output logic       miss,
  output logic [1:0] ammo,
  output logic       out_of_ammo,
  output logic       busy
);

  localparam int TW = $clog2(max_i(BLANK_CYCLES, TARGET_CYCLES)) + 1;
  localparam logic [1:0] AMMO_INIT = 2'(AMMO_MAX);

  res_state_e  state_q, state_d;
  logic [1:0]  ammo_q, ammo_d;
  logic        flash_black_q, flash_black_d;
  logic        flash_target_q, flash_target_d;
  logic        hit_q, hit_d;
  logic        miss_q, miss_d;
  logic        busy_q, busy_d;
  logic        out_of_ammo_q, out_of_ammo_d;
  logic        blank_ok_q, blank_ok_d;
  logic        seen_light_q, seen_light_d;
  logic        tmr_load;
  logic [TW-1:0] tmr_val;
  logic        tmr_done;
  logic        shot;

  assign shot = (STATE == FIRE_SHOT);

  flash_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst_n    (reset_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_comb begin
    state_d        = state_q;
    ammo_d         = ammo_q;
    flash_black_d  = 1'b0;
    flash_target_d = 1'b0;
    hit_d          = 1'b0;
    miss_d         = 1'b0;
    blank_ok_d     = blank_ok_q;
    seen_light_d   = seen_light_q;
    tmr_load       = 1'b0;
    tmr_val        = '0;
    // new_round outranks everything, including a coincident shot
    if (new_round) begin
      state_d  = RES_IDLE;
      ammo_d   = AMMO_INIT;
      tmr_load = 1'b1;
    end else begin
      unique case (state_q)
        RES_IDLE: begin
          if (shot && ammo_q != 2'd0) begin
            ammo_d        = ammo_q - 2'd1;
            state_d       = RES_BLANK;
            flash_black_d = 1'b1;
            tmr_load      = 1'b1;
            tmr_val       = TW'(BLANK_CYCLES);
          end
        end
        RES_BLANK: begin
          flash_black_d = 1'b1;
          if (tmr_done) begin
            state_d        = RES_TARGET;
            flash_black_d  = 1'b0;
            flash_target_d = 1'b1;
            blank_ok_d     = !light_sensor;
            seen_light_d   = 1'b0;
            tmr_load       = 1'b1;
            tmr_val        = TW'(TARGET_CYCLES);
          end
        end
        RES_TARGET: begin
          flash_target_d = 1'b1;
          seen_light_d   = seen_light_q | light_sensor;
          if (tmr_done) begin
            state_d        = RES_RESULT;
            flash_target_d = 1'b0;
            hit_d          = blank_ok_q & seen_light_d;
            miss_d         = !(blank_ok_q & seen_light_d);
          end
        end
        RES_RESULT: begin
          state_d = RES_IDLE;
        end
      endcase
    end
    busy_d        = (state_d != RES_IDLE);
    out_of_ammo_d = (ammo_d == 2'd0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= RES_IDLE;
      ammo_q         <= AMMO_INIT;
      flash_black_q  <= 1'b0;
      flash_target_q <= 1'b0;
      hit_q          <= 1'b0;
      miss_q         <= 1'b0;
      busy_q         <= 1'b0;
      out_of_ammo_q  <= 1'b0;
      blank_ok_q     <= 1'b0;
      seen_light_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      ammo_q         <= ammo_d;
      flash_black_q  <= flash_black_d;
      flash_target_q <= flash_target_d;
      hit_q          <= hit_d;
      miss_q         <= miss_d;
      busy_q         <= busy_d;
      out_of_ammo_q  <= out_of_ammo_d;
      blank_ok_q     <= blank_ok_d;
      seen_light_q   <= seen_light_d;
    end
  end

  assign flash_black  = flash_black_q;
  assign flash_target = flash_target_q;
  assign hit          = hit_q;
  assign miss         = miss_q;
  assign ammo         = ammo_q;
  assign out_of_ammo  = out_of_ammo_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_shot_resolver.sv
// Scoreboard bench for shot_resolver with default parameters.
module tb_shot_resolver;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] STATE = 2'b00;
  logic       light_sensor = 1'b0;
  logic       new_round = 1'b0;
  logic       flash_black, flash_target, hit, miss, out_of_ammo, busy;
  logic [1:0] ammo;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    bit hit;
    int cyc;
  } exp_t;
  exp_t sbq[$];

  shot_resolver #(
    .BLANK_CYCLES  (4),
    .TARGET_CYCLES (4),
    .AMMO_MAX      (3)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .STATE        (STATE),
    .light_sensor (light_sensor),
    .new_round    (new_round),
    .flash_black  (flash_black),
    .flash_target (flash_target),
    .hit          (hit),
    .miss         (miss),
    .ammo         (ammo),
    .out_of_ammo  (out_of_ammo),
    .busy         (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops an expected verdict whenever a pulse appears
  always @(negedge clk) begin
    if (reset_n) begin
      if (flash_black && flash_target) begin
        errors++;
        $display("FAIL flash_overlap: both flashes high (cycle %0d)", cyc);
      end
      if (hit || miss) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: hit=%0d miss=%0d with none expected (cycle %0d)",
                   hit, miss, cyc);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("pulse_hit", int'(hit), int'(e.hit));
          chk("pulse_miss", int'(miss), int'(!e.hit));
          chk("pulse_cycle", cyc, e.cyc);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic shot(input bit lamp, input int dup_k, input bit exp_hit);
    int c0;
    step();
    c0 = cyc;
    STATE = 2'b11;
    light_sensor = lamp;
    sbq.push_back('{exp_hit, c0 + 9});
    for (int k = 1; k <= 10; k++) begin
      step();
      STATE = (k == dup_k) ? 2'b11 : 2'b01;
      light_sensor = lamp | (k == 6);
      @(negedge clk);
      chk("flash_black", int'(flash_black), int'(k >= 1 && k <= 4));
      chk("flash_target", int'(flash_target), int'(k >= 5 && k <= 8));
    end
    STATE = 2'b01;
    light_sensor = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      STATE = 2'b01;
      @(negedge clk);
      chk("idle_black", int'(flash_black), 0);
      chk("idle_target", int'(flash_target), 0);
    end
  endtask

  task automatic pulse_new_round();
    step();
    new_round = 1'b1;
    step();
    new_round = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    chk("rst_ammo", int'(ammo), 3);
    chk("rst_black", int'(flash_black), 0);
    chk("rst_target", int'(flash_target), 0);
    chk("rst_hit", int'(hit), 0);
    chk("rst_miss", int'(miss), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ooa", int'(out_of_ammo), 0);
    step();
    reset_n = 1'b1;
    STATE = 2'b01;

    // Basic hit
    shot(1'b0, 0, 1'b1);
    chk("ammo_after_1", int'(ammo), 2);
    chk("busy_after_1", int'(busy), 0);

    // Lamp cheat: light through the black frame
    shot(1'b1, 0, 1'b0);
    chk("ammo_after_2", int'(ammo), 1);
    chk("ooa_at_1", int'(out_of_ammo), 0);

    // Last round, then an empty trigger pull
    shot(1'b0, 0, 1'b1);
    chk("ammo_after_3", int'(ammo), 0);
    chk("ooa_at_0", int'(out_of_ammo), 1);
    step();
    STATE = 2'b11;
    idle_cycles(12);
    chk("ammo_empty_hold", int'(ammo), 0);
    chk("busy_empty", int'(busy), 0);

    // Reload, then a shot while busy
    pulse_new_round();
    @(negedge clk);
    chk("ammo_reload", int'(ammo), 3);
    chk("ooa_reload", int'(out_of_ammo), 0);
    shot(1'b0, 3, 1'b1);
    chk("ammo_busy_drop", int'(ammo), 2);

    // STATE 10 is not a shot
    step();
    STATE = 2'b10;
    idle_cycles(6);
    chk("ammo_state10", int'(ammo), 2);

    // Abort with a coincident shot
    pulse_new_round();
    step();
    STATE = 2'b11;
    light_sensor = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      step();
      STATE = (k == 6) ? 2'b11 : 2'b01;
      new_round = (k == 6);
      light_sensor = (k == 5);
    end
    @(negedge clk);
    chk("abort_busy", int'(busy), 0);
    chk("abort_target", int'(flash_target), 0);
    chk("abort_ammo", int'(ammo), 3);
    idle_cycles(12);
    chk("abort_ammo_late", int'(ammo), 3);

    // Asynchronous reset mid-target
    step();
    STATE = 2'b11;
    for (int k = 1; k <= 5; k++) begin
      step();
      STATE = 2'b01;
    end
    @(negedge clk);
    chk("pre_rst_target", int'(flash_target), 1);
    chk("pre_rst_ammo", int'(ammo), 2);
    reset_n = 1'b0;
    #1;
    chk("arst_target", int'(flash_target), 0);
    chk("arst_ammo", int'(ammo), 3);
    chk("arst_busy", int'(busy), 0);
    step();
    reset_n = 1'b1;
    idle_cycles(12);
    chk("arst_ammo_late", int'(ammo), 3);

    chk("sb_drained", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
